// File: rtl/vram_arbiter_if.sv
// Bus bundle between the video fetcher, the 8080 CPU port, the video RAM and the arbiter.
// The arbiter takes the slave view; requesters and the RAM take the master view.
interface vram_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    logic              VID_REQ;
    logic [ADDR_W-1:0] VID_ADDR;
    logic              VID_GNT;
    logic              VID_VALID;
    logic [DATA_W-1:0] VID_DATA;

    logic              CPU_REQ;
    logic              CPU_WE;
    logic [ADDR_W-1:0] CPU_ADDR;
    logic [DATA_W-1:0] CPU_WDATA;
    logic              CPU_GNT;
    logic              CPU_VALID;
    logic [DATA_W-1:0] CPU_RDATA;

    logic [ADDR_W-1:0] RAM_ADDR;
    logic              RAM_WE;
    logic [DATA_W-1:0] RAM_WDATA;
    logic [DATA_W-1:0] RAM_RDATA;

    logic              VID_LATE;
    logic [7:0]        VID_LATE_CNT;

    modport slave (
        input  VID_REQ, VID_ADDR, CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA, RAM_RDATA,
        output VID_GNT, VID_VALID, VID_DATA, CPU_GNT, CPU_VALID, CPU_RDATA,
               RAM_ADDR, RAM_WE, RAM_WDATA, VID_LATE, VID_LATE_CNT
    );

    modport master (
        output VID_REQ, VID_ADDR, CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA, RAM_RDATA,
        input  VID_GNT, VID_VALID, VID_DATA, CPU_GNT, CPU_VALID, CPU_RDATA,
               RAM_ADDR, RAM_WE, RAM_WDATA, VID_LATE, VID_LATE_CNT
    );
endinterface

// File: rtl/vram_arbiter.sv
// Video-priority arbiter for the single-port Space Invaders video RAM, with a bounded CPU
// wait, a fixed 3-edge response pipeline and a saturating count of delayed video fetches.
module vram_arbiter #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 8,
    parameter int CPU_MAX_WAIT = 4
) (
    input  logic          CLK_25MHZ,
    input  logic          RESET_N,
    vram_arbiter_if.slave bus
);
    localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);
    localparam logic       PORT_VID = 1'b0;
    localparam logic       PORT_CPU = 1'b1;

    typedef struct packed {
        logic valid;
        logic port;
        logic we;
    } tag_t;

    logic [3:0]        starve_q, starve_d;
    logic              late_q, late_d;
    logic [7:0]        late_cnt_q, late_cnt_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    tag_t              tag1_q, tag1_d, tag2_q;
    logic              vid_valid_q, vid_valid_d;
    logic              cpu_valid_q, cpu_valid_d;
    logic [DATA_W-1:0] vid_data_q, vid_data_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              starved_s, cpu_gnt_s, vid_gnt_s;

    // Grant decode: only REQ and registered starve state feed the grants; reset blocks both.
    always_comb begin
        starved_s = (starve_q == MAX_WAIT);
        cpu_gnt_s = RESET_N & bus.CPU_REQ & (starved_s | ~bus.VID_REQ);
        vid_gnt_s = RESET_N & bus.VID_REQ & ~cpu_gnt_s;
    end

    // Next-state logic for starve tracking, RAM command, tag pipeline and responses.
    always_comb begin
        if (!bus.CPU_REQ || cpu_gnt_s) begin
            starve_d = 4'd0;
        end else if (starve_q < MAX_WAIT) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = starve_q;
        end

        late_d = bus.VID_REQ & cpu_gnt_s & starved_s;
        if (late_q && (late_cnt_q != 8'hFF)) begin
            late_cnt_d = late_cnt_q + 8'd1;
        end else begin
            late_cnt_d = late_cnt_q;
        end

        // Idle cycles keep address and write data, only the write strobe drops.
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        tag1_d      = '0;
        if (cpu_gnt_s) begin
            ram_addr_d = bus.CPU_ADDR;
            ram_we_d   = bus.CPU_WE;
            if (bus.CPU_WE) begin
                ram_wdata_d = bus.CPU_WDATA;
            end else begin
                ram_wdata_d = ram_wdata_q;
            end
            tag1_d = {1'b1, PORT_CPU, bus.CPU_WE};
        end else if (vid_gnt_s) begin
            ram_addr_d = bus.VID_ADDR;
            tag1_d     = {1'b1, PORT_VID, 1'b0};
        end else begin
            tag1_d = '0;
        end

        vid_valid_d = tag2_q.valid & (tag2_q.port == PORT_VID);
        cpu_valid_d = tag2_q.valid & (tag2_q.port == PORT_CPU);
        if (vid_valid_d) begin
            vid_data_d = bus.RAM_RDATA;
        end else begin
            vid_data_d = vid_data_q;
        end
        if (cpu_valid_d && !tag2_q.we) begin
            cpu_rdata_d = bus.RAM_RDATA;
        end else begin
            cpu_rdata_d = cpu_rdata_q;
        end
    end

    // State registers; reset also kills any in-flight tags so they never return VALID.
    always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            starve_q    <= 4'd0;
            late_q      <= 1'b0;
            late_cnt_q  <= 8'd0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            tag1_q      <= '0;
            tag2_q      <= '0;
            vid_valid_q <= 1'b0;
            cpu_valid_q <= 1'b0;
            vid_data_q  <= '0;
            cpu_rdata_q <= '0;
        end else begin
            starve_q    <= starve_d;
            late_q      <= late_d;
            late_cnt_q  <= late_cnt_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            tag1_q      <= tag1_d;
            tag2_q      <= tag1_q;
            vid_valid_q <= vid_valid_d;
            cpu_valid_q <= cpu_valid_d;
            vid_data_q  <= vid_data_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    assign bus.VID_GNT      = vid_gnt_s;
    assign bus.CPU_GNT      = cpu_gnt_s;
    assign bus.VID_VALID    = vid_valid_q;
    assign bus.VID_DATA     = vid_data_q;
    assign bus.CPU_VALID    = cpu_valid_q;
    assign bus.CPU_RDATA    = cpu_rdata_q;
    assign bus.RAM_ADDR     = ram_addr_q;
    assign bus.RAM_WE       = ram_we_q;
    assign bus.RAM_WDATA    = ram_wdata_q;
    assign bus.VID_LATE     = late_q;
    assign bus.VID_LATE_CNT = late_cnt_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: tasks push expected responses at accept time, a
// monitor pops them when VALID pulses and checks data and 3-edge latency.
`timescale 1ns/1ps
module tb_vram_arbiter;
    localparam int AW   = 13;
    localparam int DW   = 8;
    localparam int MAXW = 4;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       we;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    exp_t       vq[$];
    exp_t       cq[$];
    exp_t       me;
    logic [7:0] ram_mem [0:8191];
    logic [7:0] ref_mem [0:8191];
    logic [7:0] exp_cpu_rdata = 8'h00;

    vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CPU_MAX_WAIT(MAXW)) dut (
        .CLK_25MHZ(clk),
        .RESET_N  (rst_n),
        .bus      (bus.slave)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM, one-cycle read latency, read-before-write.
    always @(posedge clk) begin
        if (bus.RAM_WE === 1'b1) ram_mem[bus.RAM_ADDR] <= bus.RAM_WDATA;
        bus.RAM_RDATA <= ram_mem[bus.RAM_ADDR];
    end

    // Response monitor: every VALID must match the head of its port's queue in data and cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.VID_VALID === 1'b1) begin
                total++;
                if (vq.size() == 0) begin
                    bad++;
                    $display("FAIL vid_unexpected cyc=%0d data=%h, required no pulse", cyc, bus.VID_DATA);
                end else begin
                    me = vq.pop_front();
                    if (me.cyc != cyc || bus.VID_DATA !== me.data) begin
                        bad++;
                        $display("FAIL vid_resp got cyc=%0d data=%h, required cyc=%0d data=%h",
                                 cyc, bus.VID_DATA, me.cyc, me.data);
                    end
                end
            end else if (vq.size() != 0 && vq[0].cyc <= cyc) begin
                total++;
                bad++;
                $display("FAIL vid_missing no pulse at cyc=%0d, required at cyc=%0d", cyc, vq[0].cyc);
                void'(vq.pop_front());
            end
            if (bus.CPU_VALID === 1'b1) begin
                total++;
                if (cq.size() == 0) begin
                    bad++;
                    $display("FAIL cpu_unexpected cyc=%0d, required no pulse", cyc);
                end else begin
                    me = cq.pop_front();
                    if (!me.we) exp_cpu_rdata = me.data;
                    if (me.cyc != cyc || bus.CPU_RDATA !== exp_cpu_rdata) begin
                        bad++;
                        $display("FAIL cpu_resp got cyc=%0d rdata=%h, required cyc=%0d rdata=%h we=%0b",
                                 cyc, bus.CPU_RDATA, me.cyc, exp_cpu_rdata, me.we);
                    end
                end
            end else if (cq.size() != 0 && cq[0].cyc <= cyc) begin
                total++;
                bad++;
                $display("FAIL cpu_missing no pulse at cyc=%0d, required at cyc=%0d", cyc, cq[0].cyc);
                void'(cq.pop_front());
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((vq.size() != 0 || cq.size() != 0) && n < 20) begin
            next_cycle();
            n++;
        end
        total++;
        if (vq.size() != 0 || cq.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout pending vid=%0d cpu=%0d, required 0 0", vq.size(), cq.size());
            vq.delete();
            cq.delete();
        end
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.VID_REQ = 1'b1; bus.VID_ADDR = 13'h0011;
        bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b1; bus.CPU_ADDR = 13'h0022; bus.CPU_WDATA = 8'h33;
        exp_cpu_rdata = 8'h00;
        next_cycle();
        next_cycle();
        @(negedge clk);
        total++;
        if ({bus.VID_GNT, bus.CPU_GNT} !== 2'b00) begin
            bad++; $display("FAIL reset_gnt got %b, required 00", {bus.VID_GNT, bus.CPU_GNT});
        end
        total++;
        if ({bus.VID_VALID, bus.CPU_VALID, bus.VID_LATE, bus.RAM_WE} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got %b, required 0000",
                            {bus.VID_VALID, bus.CPU_VALID, bus.VID_LATE, bus.RAM_WE});
        end
        total++;
        if ({bus.VID_DATA, bus.CPU_RDATA, bus.RAM_WDATA} !== 24'h000000) begin
            bad++; $display("FAIL reset_data got %h, required 000000",
                            {bus.VID_DATA, bus.CPU_RDATA, bus.RAM_WDATA});
        end
        total++;
        if (bus.RAM_ADDR !== 13'h0000 || bus.VID_LATE_CNT !== 8'h00) begin
            bad++; $display("FAIL reset_addr_cnt got %h/%h, required 0000/00", bus.RAM_ADDR, bus.VID_LATE_CNT);
        end
        bus.VID_REQ = 1'b0;
        bus.CPU_REQ = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if (bus.RAM_WE !== 1'b0) begin
                bad++; $display("FAIL idle_ram_we cycle %0d got %b, required 0", i, bus.RAM_WE);
            end
            next_cycle();
        end
    endtask

    task automatic test_video();
        ram_mem[13'h0123] = 8'hA5;
        ref_mem[13'h0123] = 8'hA5;
        bus.VID_REQ  = 1'b1;
        bus.VID_ADDR = 13'h0123;
        @(negedge clk);
        total++;
        if ({bus.VID_GNT, bus.CPU_GNT} !== 2'b10) begin
            bad++; $display("FAIL video_gnt got %b, required 10", {bus.VID_GNT, bus.CPU_GNT});
        end
        vq.push_back('{cyc + 3, ref_mem[13'h0123], 1'b0});
        next_cycle();
        bus.VID_REQ  = 1'b0;
        bus.VID_ADDR = 13'h0000;
        @(negedge clk);
        total++;
        if (bus.RAM_ADDR !== 13'h0123 || bus.RAM_WE !== 1'b0) begin
            bad++; $display("FAIL video_ram_cmd got %h/%b, required 0123/0", bus.RAM_ADDR, bus.RAM_WE);
        end
        next_cycle();
        drain();
    endtask

    task automatic test_cpu_wr_rd();
        bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b1; bus.CPU_ADDR = 13'h1FFF; bus.CPU_WDATA = 8'h3C;
        @(negedge clk);
        total++;
        if ({bus.CPU_GNT, bus.RAM_WE} !== 2'b10) begin
            bad++; $display("FAIL cpu_wr_gnt got gnt/we %b, required 10", {bus.CPU_GNT, bus.RAM_WE});
        end
        cq.push_back('{cyc + 3, 8'h00, 1'b1});
        ref_mem[13'h1FFF] = 8'h3C;
        next_cycle();
        bus.CPU_WE = 1'b0; bus.CPU_WDATA = 8'hFF;
        @(negedge clk);
        total++;
        if (bus.CPU_GNT !== 1'b1 || bus.RAM_WE !== 1'b1 || bus.RAM_ADDR !== 13'h1FFF || bus.RAM_WDATA !== 8'h3C) begin
            bad++; $display("FAIL cpu_wr_cmd got gnt=%b we=%b addr=%h wdata=%h, required 1 1 1fff 3c",
                            bus.CPU_GNT, bus.RAM_WE, bus.RAM_ADDR, bus.RAM_WDATA);
        end
        cq.push_back('{cyc + 3, ref_mem[13'h1FFF], 1'b0});
        next_cycle();
        bus.CPU_REQ = 1'b0;
        @(negedge clk);
        total++;
        if (bus.RAM_WE !== 1'b0 || bus.RAM_WDATA !== 8'h3C) begin
            bad++; $display("FAIL cpu_rd_cmd got we=%b wdata=%h, required 0 3c", bus.RAM_WE, bus.RAM_WDATA);
        end
        next_cycle();
        drain();
    endtask

    task automatic test_contention();
        bus.VID_REQ = 1'b1; bus.VID_ADDR = 13'h0456;
        bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b0; bus.CPU_ADDR = 13'h0789;
        @(negedge clk);
        total++;
        if ({bus.VID_GNT, bus.CPU_GNT} !== 2'b10) begin
            bad++; $display("FAIL contend_c0 got %b, required 10", {bus.VID_GNT, bus.CPU_GNT});
        end
        vq.push_back('{cyc + 3, ref_mem[13'h0456], 1'b0});
        next_cycle();
        bus.VID_REQ = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.VID_GNT, bus.CPU_GNT} !== 2'b01) begin
            bad++; $display("FAIL contend_c1 got %b, required 01", {bus.VID_GNT, bus.CPU_GNT});
        end
        cq.push_back('{cyc + 3, ref_mem[13'h0789], 1'b0});
        next_cycle();
        bus.CPU_REQ = 1'b0;
        drain();
    endtask

    task automatic test_starvation();
        int         s       = 0;
        int         cnt_exp = 0;
        logic       late_exp = 1'b0;
        logic       ec;
        logic [12:0] va  = 13'h0005;
        logic [12:0] ca  = 13'h1000;
        logic        cwe = 1'b0;
        logic [7:0]  cwd = 8'h00;
        bus.VID_REQ = 1'b1; bus.VID_ADDR = va;
        bus.CPU_REQ = 1'b1; bus.CPU_WE = cwe; bus.CPU_ADDR = ca; bus.CPU_WDATA = cwd;
        for (int i = 0; i < 1290; i++) begin
            @(negedge clk);
            ec = (s == MAXW);
            total++;
            if ({bus.VID_GNT, bus.CPU_GNT} !== {~ec, ec}) begin
                bad++; $display("FAIL starve_gnt step %0d got %b, required %b", i,
                                {bus.VID_GNT, bus.CPU_GNT}, {~ec, ec});
            end
            total++;
            if (bus.VID_LATE !== late_exp) begin
                bad++; $display("FAIL vid_late step %0d got %b, required %b", i, bus.VID_LATE, late_exp);
            end
            total++;
            if (bus.VID_LATE_CNT !== 8'(cnt_exp)) begin
                bad++; $display("FAIL late_cnt step %0d got %0d, required %0d", i, bus.VID_LATE_CNT, cnt_exp);
            end
            if (late_exp && cnt_exp < 255) cnt_exp++;
            late_exp = ec;
            if (ec) begin
                if (cwe) begin
                    cq.push_back('{cyc + 3, 8'h00, 1'b1});
                    ref_mem[ca] = cwd;
                end else begin
                    cq.push_back('{cyc + 3, ref_mem[ca], 1'b0});
                end
                s   = 0;
                ca  = ca + 13'd3;
                cwe = 1'($urandom_range(0, 1));
                cwd = 8'($urandom);
            end else begin
                vq.push_back('{cyc + 3, ref_mem[va], 1'b0});
                s  = s + 1;
                va = va + 13'd7;
            end
            next_cycle();
            bus.VID_ADDR = va; bus.CPU_ADDR = ca; bus.CPU_WE = cwe; bus.CPU_WDATA = cwd;
        end
        bus.VID_REQ = 1'b0;
        bus.CPU_REQ = 1'b0;
        drain();
        total++;
        if (bus.VID_LATE_CNT !== 8'hFF) begin
            bad++; $display("FAIL late_cnt_sat got %0d, required 255", bus.VID_LATE_CNT);
        end
    endtask

    task automatic test_reset_mid();
        bus.VID_REQ = 1'b1; bus.VID_ADDR = 13'h0040;
        @(negedge clk);
        total++;
        if (bus.VID_GNT !== 1'b1) begin
            bad++; $display("FAIL mid_accept got %b, required 1", bus.VID_GNT);
        end
        next_cycle();
        rst_n = 1'b0;
        bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b1;
        exp_cpu_rdata = 8'h00;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if ({bus.VID_GNT, bus.CPU_GNT, bus.VID_VALID, bus.RAM_WE} !== 4'b0000) begin
                bad++; $display("FAIL mid_reset_hold %0d got %b, required 0000", i,
                                {bus.VID_GNT, bus.CPU_GNT, bus.VID_VALID, bus.RAM_WE});
            end
            next_cycle();
        end
        bus.CPU_REQ = 1'b0; bus.CPU_WE = 1'b0;
        bus.VID_ADDR = 13'h0000;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.VID_GNT !== 1'b1) begin
            bad++; $display("FAIL mid_reissue_gnt got %b, required 1", bus.VID_GNT);
        end
        vq.push_back('{cyc + 3, ref_mem[13'h0000], 1'b0});
        next_cycle();
        bus.VID_REQ = 1'b0;
        drain();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cyc=%0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 8192; a++) begin
            ram_mem[a] = 8'(a) ^ 8'h5A;
            ref_mem[a] = 8'(a) ^ 8'h5A;
        end
        bus.VID_REQ = 1'b0; bus.VID_ADDR = 13'h0000;
        bus.CPU_REQ = 1'b0; bus.CPU_WE = 1'b0; bus.CPU_ADDR = 13'h0000; bus.CPU_WDATA = 8'h00;
        test_reset();
        test_video();
        test_cpu_wr_rd();
        test_contention();
        test_starvation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
